// File: rtl/cnn_pkg.sv
// Shared types and constants for the SimpleCNN layer sequencer.
package cnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_RELU,
    S_POOL,
    S_FC,
    S_DONE,
    S_ERR
  } seq_state_t;

  localparam logic [1:0] STG_CONV = 2'd0;
  localparam logic [1:0] STG_RELU = 2'd1;
  localparam logic [1:0] STG_POOL = 2'd2;
  localparam logic [1:0] STG_FC   = 2'd3;

  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_CNT_W          = 16;

  function automatic logic [1:0] stage_index(input seq_state_t s);
    case (s)
      S_RELU:  return STG_RELU;
      S_POOL:  return STG_POOL;
      S_FC:    return STG_FC;
      default: return STG_CONV;
    endcase
  endfunction

endpackage

// File: rtl/cnn_layer_sequencer_watchdog.sv
// Per-stage watchdog: counts cycles since the last clear and flags the
// final allowed cycle of a stage.
module seq_watchdog #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else              count <= count + 1'b1;
  end

  // Compare at 32 bits so a limit wider than the counter can never alias.
  assign expired = (32'(count) == LIMIT);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Frame controller stepping conv/relu/pool/fc with cumulative enables and a
// per-stage watchdog. Optional per-stage cycle counters: SEQ_PERF_CNT_EN.
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               err_clr,
  input  logic               conv_done,
  input  logic               relu_done,
  input  logic               pool_done,
  input  logic               fc_done,
  output logic               conv_enable,
  output logic               relu_enable,
  output logic               pool_enable,
  output logic               fc_enable,
  output logic               busy,
  output logic               frame_done,
  output logic               error,
  output logic [1:0]         err_stage,
  output logic [4*CNT_W-1:0] perf_cycles
);

  seq_state_t state, next_state;
  logic       cur_done;
  logic       stage_active;
  logic       wd_clear;
  logic       wd_expired;
  logic       nxt_conv_en, nxt_relu_en, nxt_pool_en, nxt_fc_en, nxt_error;

  assign stage_active = (state inside {S_CONV, S_RELU, S_POOL, S_FC});
  assign wd_clear     = (next_state != state) || !stage_active;

  seq_watchdog #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    cur_done    = 1'b0;
    case (state)
      S_CONV:  cur_done = conv_done;
      S_RELU:  cur_done = relu_done;
      S_POOL:  cur_done = pool_done;
      S_FC:    cur_done = fc_done;
      default: cur_done = 1'b0;
    endcase

    // frame_done is still high in the first IDLE cycle after DONE; a start
    // there is refused so the next frame begins the cycle after the pulse.
    case (state)
      S_IDLE: if (start && !frame_done) next_state = S_CONV;
      S_CONV: if (cur_done) next_state = S_RELU; else if (wd_expired) next_state = S_ERR;
      S_RELU: if (cur_done) next_state = S_POOL; else if (wd_expired) next_state = S_ERR;
      S_POOL: if (cur_done) next_state = S_FC;   else if (wd_expired) next_state = S_ERR;
      S_FC:   if (cur_done) next_state = S_DONE; else if (wd_expired) next_state = S_ERR;
      S_DONE: next_state = S_IDLE;
      S_ERR:  if (err_clr) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase

    nxt_conv_en = (next_state inside {S_CONV, S_RELU, S_POOL, S_FC});
    nxt_relu_en = (next_state inside {S_RELU, S_POOL, S_FC});
    nxt_pool_en = (next_state inside {S_POOL, S_FC});
    nxt_fc_en   = (next_state == S_FC);
    nxt_error   = (next_state == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_enable <= 1'b0;
      relu_enable <= 1'b0;
      pool_enable <= 1'b0;
      fc_enable   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      err_stage   <= 2'd0;
    end else begin
      conv_enable <= nxt_conv_en;
      relu_enable <= nxt_relu_en;
      pool_enable <= nxt_pool_en;
      fc_enable   <= nxt_fc_en;
      busy        <= nxt_conv_en;
      frame_done  <= (state == S_DONE);
      error       <= nxt_error;
      if (nxt_error && (state != S_ERR)) err_stage <= stage_index(state);
    end
  end

`ifdef SEQ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]   stage_cnt;
  logic [CNT_W-1:0]   stage_len;
  logic [4*CNT_W-1:0] perf_q;

  assign stage_len = (stage_cnt == CNT_MAX) ? CNT_MAX : stage_cnt + 1'b1;

  // stage_len is the saturated length including the current cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_cnt <= '0;
      perf_q    <= '0;
    end else begin
      if ((state == S_IDLE) && (next_state == S_CONV)) perf_q <= '0;
      if (stage_active && (next_state != state)) begin
        perf_q[int'(stage_index(state))*CNT_W +: CNT_W] <= stage_len;
        stage_cnt <= '0;
      end else if (stage_active) begin
        stage_cnt <= stage_len;
      end else begin
        stage_cnt <= '0;
      end
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Randomised and directed bench for cnn_layer_sequencer against a timeline
// model of each frame (stage entry cycles derived from per-stage done delays).
module tb_cnn_layer_sequencer;

  localparam int T  = 8;
  localparam int CW = 16;

  logic          clk, rst, start, err_clr;
  logic          conv_done, relu_done, pool_done, fc_done;
  logic          conv_enable, relu_enable, pool_enable, fc_enable;
  logic          busy, frame_done, error;
  logic [1:0]    err_stage;
  logic [4*CW-1:0] perf_cycles;

  int checks, passed, fails, frame_no;
  int k[4];
  int entry[5];
  int err_stg, err_at, clr_at, rst_at, t_end;

  cnn_layer_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .err_clr(err_clr),
    .conv_done(conv_done), .relu_done(relu_done), .pool_done(pool_done), .fc_done(fc_done),
    .conv_enable(conv_enable), .relu_enable(relu_enable), .pool_enable(pool_enable),
    .fc_enable(fc_enable), .busy(busy), .frame_done(frame_done), .error(error),
    .err_stage(err_stage), .perf_cycles(perf_cycles)
  );

`ifdef SEQ_PERF_CNT_EN
  logic        s_start, s_conv_done, s_relu_done, s_pool_done, s_fc_done, s_err_clr;
  logic        s_conv_en, s_relu_en, s_pool_en, s_fc_en, s_busy, s_frame_done, s_error;
  logic [1:0]  s_err_stage;
  logic [15:0] s_perf;

  cnn_layer_sequencer #(.TIMEOUT_CYCLES(30), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .err_clr(s_err_clr),
    .conv_done(s_conv_done), .relu_done(s_relu_done), .pool_done(s_pool_done), .fc_done(s_fc_done),
    .conv_enable(s_conv_en), .relu_enable(s_relu_en), .pool_enable(s_pool_en),
    .fc_enable(s_fc_en), .busy(s_busy), .frame_done(s_frame_done), .error(s_error),
    .err_stage(s_err_stage), .perf_cycles(s_perf)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Timeline of one frame: cycle 0 carries start, stage s is entered at
  // entry[s] and its done arrives k[s] cycles later; k >= T means a stall.
  function automatic void plan();
    entry[0] = 1;
    err_stg  = -1;
    err_at   = 1 << 30;
    for (int s = 0; s < 4; s++) begin
      if (err_stg < 0 && k[s] >= T) begin
        err_stg = s;
        err_at  = entry[s] + T;
      end
      entry[s+1] = (err_stg >= 0) ? entry[s] + 1000 : entry[s] + k[s] + 1;
    end
    clr_at = err_at + 2;
    if (rst_at >= 0)       t_end = rst_at + 1;
    else if (err_stg >= 0) t_end = clr_at + 1;
    else                   t_end = entry[4] + 1;
  endfunction

  function automatic int cur_stage(input int t);
    if (rst_at >= 0 && t > rst_at) return -1;
    if (err_stg >= 0 && t >= err_at) return -1;
    for (int s = 0; s < 4; s++)
      if (t >= entry[s] && t < entry[s+1]) return s;
    return -1;
  endfunction

  // {conv,relu,pool,fc,busy,frame_done,error,err_stage[1:0]}
  function automatic logic [8:0] model_out(input int t);
    logic [8:0] v;
    int cs;
    v  = '0;
    cs = cur_stage(t);
    if (cs >= 0) begin
      for (int i = 0; i <= cs; i++) v[8-i] = 1'b1;
      v[4] = 1'b1;
    end else if (err_stg >= 0 && rst_at < 0 && t >= err_at && t <= clr_at) begin
      v[2]   = 1'b1;
      v[1:0] = 2'(err_stg);
    end else if (err_stg < 0 && rst_at < 0 && t == entry[4] + 1) begin
      v[3] = 1'b1;
    end
    return v;
  endfunction

  task automatic apply_stimulus(input int k0, input int k1, input int k2, input int k3,
                                input int r_at, input int spur);
    logic [8:0] obs_v;
    logic [3:0] d;
    logic [63:0] perf_exp;
    int cs;
    bit ok_spur;
    k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
    rst_at = r_at;
    plan();
    for (int t = 0; t <= t_end; t++) begin
      obs_v = {conv_enable, relu_enable, pool_enable, fc_enable, busy, frame_done, error,
               error ? err_stage : 2'b00};
      check_output($sformatf("frame%0d_t%0d", frame_no, t), 64'(obs_v), 64'(model_out(t)));
      if (t == t_end) begin
`ifdef SEQ_PERF_CNT_EN
        perf_exp = '0;
        if (rst_at < 0 && err_stg < 0)
          perf_exp = {16'(k[3]+1), 16'(k[2]+1), 16'(k[1]+1), 16'(k[0]+1)};
        if (err_stg < 0)
          check_output($sformatf("frame%0d_perf", frame_no), perf_cycles, perf_exp);
`else
        perf_exp = '0;
        check_output($sformatf("frame%0d_perf", frame_no), perf_cycles, perf_exp);
`endif
      end
      cs = cur_stage(t);
      for (int s = 0; s < 4; s++) begin
        if (s == cs && t == entry[s] + k[s]) d[s] = 1'b1;
        else if (s == cs)                   d[s] = 1'b0;
        else                                d[s] = 1'($urandom_range(0, 1));
      end
      {fc_done, pool_done, relu_done, conv_done} = d;
      ok_spur = (t >= 1 && t < t_end) || (t == t_end && err_stg < 0 && rst_at < 0);
      if (t == 0)         start = 1'b1;
      else if (spur == 1) start = ok_spur && (t == entry[1] || t == entry[4] || t == t_end);
      else if (spur == 2) start = ok_spur && ($urandom_range(0, 3) == 0);
      else                start = 1'b0;
      err_clr = (err_stg >= 0 && t == clr_at);
      rst     = (t == rst_at);
      @(posedge clk); #1;
    end
    frame_no++;
  endtask

  initial begin
    checks = 0; passed = 0; fails = 0; frame_no = 0;
    rst = 1'b1; start = 1'b0; err_clr = 1'b0;
    conv_done = 1'b0; relu_done = 1'b0; pool_done = 1'b0; fc_done = 1'b0;
`ifdef SEQ_PERF_CNT_EN
    s_start = 1'b0; s_conv_done = 1'b0; s_relu_done = 1'b0;
    s_pool_done = 1'b0; s_fc_done = 1'b0; s_err_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_outputs",
                 64'({conv_enable, relu_enable, pool_enable, fc_enable, busy, frame_done, error, err_stage}),
                 64'(0));
    check_output("reset_perf", perf_cycles, 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] nominal frame");
    apply_stimulus(1, 1, 1, 1, -1, 0);
    $display("[TB] pool timeout then err_clr");
    apply_stimulus(0, 0, 100, 0, -1, 0);
    $display("[TB] relu done on the expiry cycle");
    apply_stimulus(0, T-1, 0, 0, -1, 0);
    $display("[TB] start during RELU and DONE");
    apply_stimulus(1, 1, 1, 1, -1, 1);
    $display("[TB] reset in POOL, then a normal frame");
    apply_stimulus(1, 1, 5, 1, 7, 0);
    apply_stimulus(1, 1, 1, 1, -1, 0);
    $display("[TB] long conv stage");
    apply_stimulus(4, 0, 0, 0, -1, 0);
    $display("[TB] randomised frames");
    for (int i = 0; i < 25; i++) begin
      int r[4];
      for (int s = 0; s < 4; s++)
        r[s] = ($urandom_range(0, 9) == 0) ? 100 : int'($urandom_range(0, T-1));
      apply_stimulus(r[0], r[1], r[2], r[3], -1, 2);
    end

`ifdef SEQ_PERF_CNT_EN
    $display("[TB] conv count saturation with CNT_W=4");
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    s_conv_done = 1'b1;
    @(posedge clk); #1;
    s_conv_done = 1'b0;
    check_output("sat_relu_enable", 64'(s_relu_en), 64'(1));
    check_output("sat_conv_field", 64'(s_perf[3:0]), 64'(15));
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cnn_layer_sequencer.md
Name: cnn_layer_sequencer

Overview:
- Frame-level controller for the SimpleCNN datapath. It steps conv, relu, pool and fc layers in order, one frame per start request, using each layer's enable/done pair.
- Enables are cumulative. Layers such as pool clear their registered results to zero when their enable drops, so upstream enables stay high until the whole frame finishes.
- Includes a per-stage watchdog that reports a stalled layer.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles allowed in one stage before it is flagged as an error; legal range 2..2^CNT_W-1.
- CNT_W, 16: width of the watchdog counter and the performance counters.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  single-cycle frame request; ignored unless idle
- err_clr  input  1  clears the error state
- conv_done  input  1  conv layer done
- relu_done  input  1  relu layer done
- pool_done  input  1  pool layer done (one cycle after pool_enable)
- fc_done  input  1  fc layer done
- conv_enable  output  1  conv layer enable
- relu_enable  output  1  relu layer enable
- pool_enable  output  1  pool layer enable
- fc_enable  output  1  fc layer enable
- busy  output  1  high in CONV/RELU/POOL/FC
- frame_done  output  1  one-cycle pulse when a frame completes
- error  output  1  sticky timeout flag
- err_stage  output  2  stalled stage: 0 conv, 1 relu, 2 pool, 3 fc
- perf_cycles  output  4*CNT_W  per-stage cycle counts; fc occupies the top CNT_W bits, conv the bottom

Behaviour:
- States: IDLE, CONV, RELU, POOL, FC, DONE, ERR. All outputs are registered.
- Reset (synchronous, any state including mid-frame):
  - state goes to IDLE;
  - all enables, busy, frame_done, error and the watchdog return to 0;
  - err_stage returns to 0 and perf_cycles to all-zero.
- IDLE: start=1 moves to CONV, so conv_enable is high on the next cycle.
- Stage S (CONV, RELU, POOL, FC):
  - S_enable and every earlier stage's enable are held at 1.
  - The sequencer waits for S_done=1, then moves to the next stage; its enable rises the following cycle.
  - The minimum stage length is therefore 1 cycle, with done sampled the cycle after the enable rises.
  - Done inputs from stages other than the current one are ignored.
- Watchdog:
  - Cleared on entry to each stage, then increments every cycle spent in the stage.
  - If it reaches TIMEOUT_CYCLES-1 while S_done=0, the sequencer enters ERR.
  - If S_done=1 on that same cycle, done wins and the stage advances normally.
- FC with fc_done=1 moves to DONE.
- DONE: all enables drop to 0, frame_done=1 for exactly one cycle, then IDLE. A start during DONE is ignored.
- ERR: all enables are 0 and busy=0. error=1 and err_stage is latched. The state holds until err_clr=1, which returns it to IDLE with error=0 on the next cycle. start is ignored in ERR.
- start while busy has no effect and is not queued.
- Back-to-back frames: the earliest next start is accepted is the cycle after frame_done, from IDLE.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN
- Defined:
  - perf_cycles holds, per stage, the cycle count from entry to exit.
  - Counts latch on stage exit and clear on accepting a new start.
  - Each count saturates at 2^CNT_W-1.
- Undefined: perf_cycles is tied to 0 and no counters are synthesised.

Decomposition:
- Shared package cnn_pkg holds:
  - the state enum type seq_state_t;
  - stage index constants STG_CONV=0, STG_RELU=1, STG_POOL=2, STG_FC=3;
  - default TIMEOUT_CYCLES.
- One natural sub-module: seq_watchdog (clear, count, expiry compare), instantiated once.
- Performance counters stay inline.

Test Plan:
- Nominal frame: start at cycle 0; each done arrives 1 cycle after its enable → enables rise cumulatively at cycles 1, 3, 5, 7; frame_done pulses at cycle 10; all enables are 0 at cycle 10.
- Timeout: TIMEOUT_CYCLES=8; pool_done held at 0 → ERR after 8 cycles in POOL with error=1, err_stage=2, all enables 0; err_clr → IDLE, error=0.
- Done and expiry on the same cycle: relu_done asserted exactly on the expiry cycle → proceeds to POOL with error=0.
- start issued during RELU, and again during DONE → both ignored; exactly one frame_done pulse.
- Reset mid-frame: rst asserted in POOL → next cycle IDLE with all outputs 0; a subsequent start produces a normal frame.
- With SEQ_PERF_CNT_EN defined: conv stage held 5 cycles, others 1 → perf_cycles conv field=5, others=1; with CNT_W=4 and conv stalled 20 cycles (TIMEOUT_CYCLES=30) → conv field saturates at 15.
